// File: rtl/main_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder_pkg
// Brief    : Shared cache/memory geometry, responder state encoding, helpers.
// Revision : 1.0
// ============================================================================
package main_memory_responder_pkg;

    localparam int MEM_WORD_SIZE       = 32;
    localparam int MEM_WORDS_PER_BLOCK = 4;
    localparam int MEM_BLOCK_SIZE      = MEM_WORD_SIZE * MEM_WORDS_PER_BLOCK;
    localparam int MEM_BLK_ADDR_WIDTH  = 29;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } mem_state_t;

    typedef logic [MEM_BLOCK_SIZE-1:0] block_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_memory_responder_latency_counter.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder_latency_counter
// Brief    : Loadable down-counter that times the responder's wait states.
// Revision : 1.0
// ============================================================================
module main_memory_responder_latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_value;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (dec && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign zero = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder
// Brief    : Fixed-latency block memory serving cache refills and write-backs.
// Revision : 1.0
// ============================================================================
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int WORD_SIZE       = MEM_WORD_SIZE,
    parameter int WORDS_PER_BLOCK = MEM_WORDS_PER_BLOCK,
    parameter int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
    parameter int BLK_ADDR_WIDTH  = MEM_BLK_ADDR_WIDTH,
    parameter int MEM_BLOCKS      = 256,
    parameter int MEM_ADDR_WIDTH  = $clog2(MEM_BLOCKS),
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      read_en_mem,
    input  logic                      write_en_mem,
    input  logic [BLK_ADDR_WIDTH-1:0] blk_addr,
    input  logic [BLK_ADDR_WIDTH-1:0] wb_addr,
    input  logic [BLOCK_SIZE-1:0]     dirty_block_in,
    output logic                      mem_ready,
    output logic [BLOCK_SIZE-1:0]     data_out_mem,
    output logic                      read_valid,
    output logic                      write_done
);

    localparam int c_cnt_width = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);

    // From accept the wait state lasts LATENCY-1 cycles (none when LATENCY is 1);
    // a read released by a write-back waits the full READ_LATENCY cycles.
    localparam logic [c_cnt_width-1:0] c_rd_first =
        (READ_LATENCY > 1) ? c_cnt_width'(READ_LATENCY - 2) : c_cnt_width'(0);
    localparam logic [c_cnt_width-1:0] c_wr_first =
        (WRITE_LATENCY > 1) ? c_cnt_width'(WRITE_LATENCY - 2) : c_cnt_width'(0);
    localparam logic [c_cnt_width-1:0] c_rd_queued = c_cnt_width'(READ_LATENCY - 1);

    mem_state_t r_state;
    mem_state_t w_next_state;

    logic                      r_ready;
    logic                      r_rd_pending;
    logic [MEM_ADDR_WIDTH-1:0] r_rd_addr;
    logic [MEM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [BLOCK_SIZE-1:0]     r_wr_data;
    logic [BLOCK_SIZE-1:0]     r_data_out;
    logic [BLOCK_SIZE-1:0]     r_mem [MEM_BLOCKS];

    logic                      w_accept;
    logic                      w_cnt_load;
    logic [c_cnt_width-1:0]    w_cnt_load_value;
    logic                      w_cnt_dec;
    logic                      w_cnt_zero;
    logic                      w_rd_sample;
    logic                      w_wr_commit;
    logic [MEM_ADDR_WIDTH-1:0] w_rd_index;
    logic [MEM_ADDR_WIDTH-1:0] w_wr_index;
    logic [BLOCK_SIZE-1:0]     w_wr_block;
    logic                      w_unused_addr_bits;

    // Upper address bits alias onto the same storage.
    assign w_unused_addr_bits = ^{blk_addr[BLK_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                                  wb_addr[BLK_ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

    assign w_accept  = (r_state == IDLE) && r_ready && (read_en_mem || write_en_mem);
    assign w_cnt_dec = (r_state == RD_WAIT) || (r_state == WR_WAIT);

    main_memory_responder_latency_counter #(
        .WIDTH (c_cnt_width)
    ) u_latency_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_cnt_load),
        .load_value (w_cnt_load_value),
        .dec        (w_cnt_dec),
        .zero       (w_cnt_zero)
    );

    // r_ready keeps mem_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= 1'b1;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_cnt_load       = 1'b0;
        w_cnt_load_value = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (write_en_mem) begin
                        if (WRITE_LATENCY > 1) begin
                            w_next_state     = WR_WAIT;
                            w_cnt_load       = 1'b1;
                            w_cnt_load_value = c_wr_first;
                        end else begin
                            w_next_state = WR_RESP;
                        end
                    end else if (READ_LATENCY > 1) begin
                        w_next_state     = RD_WAIT;
                        w_cnt_load       = 1'b1;
                        w_cnt_load_value = c_rd_first;
                    end else begin
                        w_next_state = RD_RESP;
                    end
                end
            end
            RD_WAIT: if (w_cnt_zero) w_next_state = RD_RESP;
            RD_RESP: w_next_state = IDLE;
            WR_WAIT: if (w_cnt_zero) w_next_state = WR_RESP;
            WR_RESP: begin
                if (r_rd_pending) begin
                    w_next_state     = RD_WAIT;
                    w_cnt_load       = 1'b1;
                    w_cnt_load_value = c_rd_queued;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_ready  = (r_state == IDLE) && r_ready;
        read_valid = (r_state == RD_RESP);
        write_done = (r_state == WR_RESP);
    end

    // A one-cycle latency op leaves IDLE straight into its response state,
    // so the array port then takes the request straight from the inputs.
    assign w_rd_sample = (w_next_state == RD_RESP);
    assign w_wr_commit = (w_next_state == WR_RESP);
    assign w_rd_index  = (r_state == IDLE) ? blk_addr[MEM_ADDR_WIDTH-1:0] : r_rd_addr;
    assign w_wr_index  = (r_state == IDLE) ? wb_addr[MEM_ADDR_WIDTH-1:0]  : r_wr_addr;
    assign w_wr_block  = (r_state == IDLE) ? dirty_block_in : r_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_data_out   <= '0;
        end else begin
            if (w_accept) begin
                r_rd_pending <= read_en_mem && write_en_mem;
                r_rd_addr    <= blk_addr[MEM_ADDR_WIDTH-1:0];
                r_wr_addr    <= wb_addr[MEM_ADDR_WIDTH-1:0];
                if (write_en_mem) begin
                    r_wr_data <= dirty_block_in;
                end
            end else if (r_state == WR_RESP) begin
                r_rd_pending <= 1'b0;
            end
            if (w_rd_sample) begin
                r_data_out <= r_mem[w_rd_index];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            r_mem[w_wr_index] <= w_wr_block;
        end
    end

    assign data_out_mem = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory_responder
// Brief    : Randomised bench for main_memory_responder against a timing model.
// Revision : 1.0
// ============================================================================
module tb_main_memory_responder;

    localparam int RL = 4;
    localparam int WL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         read_en_mem = 1'b0;
    logic         write_en_mem = 1'b0;
    logic [28:0]  blk_addr = '0;
    logic [28:0]  wb_addr = '0;
    logic [127:0] dirty_block_in = '0;
    logic         mem_ready;
    logic [127:0] data_out_mem;
    logic         read_valid;
    logic         write_done;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;

    // Model: expected event cycles, the data a refill must return, shadow array.
    int           free_cyc = 32'h3fff_ffff;
    int           rv_cyc = -1;
    int           wd_cyc = -1;
    logic [127:0] rv_data = '0;
    logic [127:0] held = '0;
    logic [127:0] mmem [256];
    logic [7:0]   undo_idx = '0;
    logic [127:0] undo_val = '0;

    main_memory_responder #(
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .blk_addr       (blk_addr),
        .wb_addr        (wb_addr),
        .dirty_block_in (dirty_block_in),
        .mem_ready      (mem_ready),
        .data_out_mem   (data_out_mem),
        .read_valid     (read_valid),
        .write_done     (write_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t cyc=%0d: got %h expected %h", name, $time, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) held = '0;
            else if (cyc == rv_cyc) held = rv_data;
            check("mem_ready", {127'd0, mem_ready}, {127'd0, rst_n && (cyc >= free_cyc)});
            check("read_valid", {127'd0, read_valid}, {127'd0, rst_n && (cyc == rv_cyc)});
            check("write_done", {127'd0, write_done}, {127'd0, rst_n && (cyc == wd_cyc)});
            check("data_out_mem", data_out_mem, held);
        end
    end

    // Applies one cycle of stimulus; the model only reacts if it expects acceptance.
    task automatic drive(input logic rd, input logic wr, input logic [28:0] ra,
                         input logic [28:0] wa, input logic [127:0] wd);
        read_en_mem    = rd;
        write_en_mem   = wr;
        blk_addr       = ra;
        wb_addr        = wa;
        dirty_block_in = wd;
        if (rst_n && (cyc >= free_cyc) && (rd || wr)) begin
            if (wr) begin
                undo_idx        = wa[7:0];
                undo_val        = mmem[wa[7:0]];
                mmem[wa[7:0]]   = wd;
                wd_cyc          = cyc + WL;
            end
            if (rd) rv_data = mmem[ra[7:0]];
            if (rd && wr) begin
                rv_cyc   = cyc + WL + RL + 1;
                free_cyc = cyc + WL + RL + 2;
            end else if (rd) begin
                rv_cyc   = cyc + RL;
                free_cyc = cyc + RL + 1;
            end else begin
                free_cyc = cyc + WL + 1;
            end
        end
        @(negedge clk);
        #2;
        read_en_mem  = 1'b0;
        write_en_mem = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_free();
        int k = 0;
        while ((cyc < free_cyc) && (k < 100)) begin
            idle();
            k++;
        end
        if (k >= 100) check("wait_free_timeout", 128'd1, 128'd0);
    endtask

    task automatic wait_rv(output int at);
        at = -1;
        for (int k = 0; k < 20; k++) begin
            if (read_valid) begin
                at = cyc;
                break;
            end
            idle();
        end
    endtask

    task automatic wait_wd(output int at);
        at = -1;
        for (int k = 0; k < 20; k++) begin
            if (write_done) begin
                at = cyc;
                break;
            end
            idle();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_ready"}, {127'd0, mem_ready}, 128'd0);
        check({tag, "_read_valid"}, {127'd0, read_valid}, 128'd0);
        check({tag, "_write_done"}, {127'd0, write_done}, 128'd0);
        check({tag, "_data"}, data_out_mem, 128'd0);
    endtask

    initial begin
        int           t0;
        int           at;
        logic [127:0] d;
        logic [28:0]  ra;
        logic [28:0]  wa;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #2;
        check_outputs_zero("reset");
        rst_n    = 1'b1;
        free_cyc = cyc + 1;

        // Fill every block through the write-back path; random upper bits alias.
        for (int i = 0; i < 256; i++) begin
            wait_free();
            if (i == 8'h05)      d = {4{32'hAAAA_AAAA}};
            else if (i == 8'h30) d = {4{32'h3030_3030}};
            else                 d = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b0, 1'b1, '0, {21'($urandom), 8'(i)}, d);
        end

        // Refill of a preloaded block.
        wait_free();
        t0 = cyc;
        drive(1'b1, 1'b0, 29'h05, '0, '0);
        wait_rv(at);
        check("t1_latency", 128'(at - t0), 128'd4);
        check("t1_data", data_out_mem, {4{32'hAAAA_AAAA}});

        // Write-back then refill of the same block.
        wait_free();
        t0 = cyc;
        drive(1'b0, 1'b1, '0, 29'h10, {4{32'hDEAD_BEEF}});
        wait_wd(at);
        check("t2_wr_latency", 128'(at - t0), 128'd4);
        wait_free();
        t0 = cyc;
        drive(1'b1, 1'b0, 29'h10, '0, '0);
        wait_rv(at);
        check("t2_rd_latency", 128'(at - t0), 128'd4);
        check("t2_data", data_out_mem, {4{32'hDEAD_BEEF}});

        // Simultaneous write-back and refill to an aliasing block.
        wait_free();
        t0 = cyc;
        drive(1'b1, 1'b1, 29'h20, 29'h20, {4{32'hBBBB_BBBB}});
        wait_wd(at);
        check("t3_wr_latency", 128'(at - t0), 128'd4);
        wait_rv(at);
        check("t3_rd_latency", 128'(at - t0), 128'd9);
        check("t3_data", data_out_mem, {4{32'hBBBB_BBBB}});

        // Requests while busy must be dropped.
        wait_free();
        t0 = cyc;
        drive(1'b1, 1'b0, 29'h05, '0, '0);
        drive(1'b1, 1'b1, 29'h10, 29'h05, {4{32'h1111_1111}});
        drive(1'b0, 1'b1, '0, 29'h05, {4{32'h2222_2222}});
        wait_rv(at);
        check("t4_latency", 128'(at - t0), 128'd4);
        check("t4_data", data_out_mem, {4{32'hAAAA_AAAA}});
        repeat (6) idle();

        // Reset in the middle of a write-back.
        wait_free();
        drive(1'b0, 1'b1, '0, 29'h30, {4{32'hCCCC_CCCC}});
        idle();
        rst_n = 1'b0;
        if (cyc < wd_cyc) mmem[undo_idx] = undo_val;
        rv_cyc   = -1;
        wd_cyc   = -1;
        free_cyc = 32'h3fff_ffff;
        #1;
        check_outputs_zero("t5_async");
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        free_cyc = cyc + 1;
        wait_free();
        drive(1'b1, 1'b0, 29'h30, '0, '0);
        wait_rv(at);
        check("t5_data", data_out_mem, {4{32'h3030_3030}});

        // Upper address bits alias onto index 0x05.
        wait_free();
        drive(1'b1, 1'b0, 29'h1_0005, '0, '0);
        wait_rv(at);
        check("t6_data", data_out_mem, {4{32'hAAAA_AAAA}});

        // Random traffic with aliasing addresses over a small index window.
        for (int n = 0; n < 800; n++) begin
            ra = {21'($urandom), 4'h0, 4'($urandom)};
            wa = {21'($urandom), 4'h0, 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, ra, wa, d);
        end
        repeat (20) idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
